// File: rtl/updown_btn_ctrl.sv
// Up/down push-button front end: synchronises two raw buttons, debounces a press,
// then emits increment/decrement pulses with hold-to-auto-repeat behaviour.
module updown_btn_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000,
  parameter logic [19:0] HOLD_CYCLES     = 20'd500000,
  parameter logic [19:0] REPEAT_CYCLES   = 20'd150000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic       incr_o,
  output logic       decr_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_LOCK     = 3'd4
  } state_t;

  // The timer counts down to zero and fires on the edge it is found at zero,
  // so loading N-1 gives exactly N cycles between load and action.
  localparam logic [19:0] DEB_LOAD = DEBOUNCE_CYCLES - 20'd1;
  localparam logic [19:0] HLD_LOAD = HOLD_CYCLES - 20'd1;
  localparam logic [19:0] RPT_LOAD = REPEAT_CYCLES - 20'd1;

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic        dir_q, dir_d;          // 1 = up, 0 = down
  logic        incr_q, incr_d;
  logic        decr_q, decr_d;
  logic        up_meta_q, up_sync_q;
  logic        dn_meta_q, dn_sync_q;

  logic        latched;
  logic        other;
  logic        pulse;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= 20'd0;
      dir_q     <= 1'b0;
      incr_q    <= 1'b0;
      decr_q    <= 1'b0;
    end else begin
      up_meta_q <= btn_up_i;
      up_sync_q <= up_meta_q;
      dn_meta_q <= btn_down_i;
      dn_sync_q <= dn_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      incr_q    <= incr_d;
      decr_q    <= decr_d;
    end
  end

  assign latched = dir_q ? up_sync_q : dn_sync_q;
  assign other   = dir_q ? dn_sync_q : up_sync_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    pulse   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (up_sync_q && dn_sync_q) begin
          state_d = ST_LOCK;
        end else if (up_sync_q) begin
          dir_d   = 1'b1;
          timer_d = DEB_LOAD;
          state_d = ST_DEBOUNCE;
        end else if (dn_sync_q) begin
          dir_d   = 1'b0;
          timer_d = DEB_LOAD;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (other) begin
          state_d = ST_LOCK;
        end else if (!latched) begin
          state_d = ST_IDLE;
        end else if (timer_q == 20'd0) begin
          pulse   = 1'b1;
          timer_d = HLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          timer_d = timer_q - 20'd1;
        end
      end
      ST_HOLD: begin
        if (other) begin
          state_d = ST_LOCK;
        end else if (!latched) begin
          state_d = ST_IDLE;
        end else if (timer_q == 20'd0) begin
          pulse   = 1'b1;
          timer_d = RPT_LOAD;
          state_d = ST_REPEAT;
        end else begin
          timer_d = timer_q - 20'd1;
        end
      end
      ST_REPEAT: begin
        if (other) begin
          state_d = ST_LOCK;
        end else if (!latched) begin
          state_d = ST_IDLE;
        end else if (timer_q == 20'd0) begin
          pulse   = 1'b1;
          timer_d = RPT_LOAD;
        end else begin
          timer_d = timer_q - 20'd1;
        end
      end
      ST_LOCK: begin
        if (!up_sync_q && !dn_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    incr_d = pulse & dir_q;
    decr_d = pulse & ~dir_q;
  end

  assign incr_o  = incr_q;
  assign decr_o  = decr_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Directed bench for updown_btn_ctrl with DEBOUNCE=4, HOLD=10, REPEAT=3.
// Pulse edges are logged by a monitor and compared against hand-derived edge numbers.
module tb_updown_btn_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_dn;
  logic       incr_o;
  logic       decr_o;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int incr_log[$];
  int decr_log[$];
  logic prev_pulse = 1'b0;

  updown_btn_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .HOLD_CYCLES    (20'd10),
    .REPEAT_CYCLES  (20'd3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn_up_i  (btn_up),
    .btn_down_i(btn_dn),
    .incr_o    (incr_o),
    .decr_o    (decr_o),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (incr_o || decr_o) begin
      checks++;
      if ((incr_o && decr_o) || prev_pulse) begin
        errors++;
        $display("FAIL pulse_shape cyc=%0d incr=%b decr=%b prev=%b (required single isolated pulse)",
                 cyc, incr_o, decr_o, prev_pulse);
      end
    end
    if (incr_o) incr_log.push_back(cyc);
    if (decr_o) decr_log.push_back(cyc);
    prev_pulse = incr_o | decr_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; btn_up = 1'b1; btn_dn = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || incr_o !== 1'b0 || decr_o !== 1'b0) begin
      errors++;
      $display("FAIL reset state=%0d incr=%b decr=%b (required 0 0 0)", state_o, incr_o, decr_o);
    end
    btn_up = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle state=%0d (required 0)", state_o);
    end
    $display("test_reset done at cyc=%0d", cyc);
  endtask

  task automatic test_single_press();
    int t;
    incr_log.delete(); decr_log.delete();
    btn_up = 1'b1; t = cyc + 1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL single_debounce_state state=%0d (required 1)", state_o);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (state_o !== 3'd2 || incr_o !== 1'b1) begin
      errors++;
      $display("FAIL single_hold_entry state=%0d incr=%b (required 2 1)", state_o, incr_o);
    end
    @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (incr_log.size() != 1 || incr_log[0] != t + 6) begin
      errors++;
      $display("FAIL single_incr count=%0d first=%0d (required 1 pulse at %0d)",
               incr_log.size(), (incr_log.size() > 0) ? incr_log[0] : -1, t + 6);
    end
    checks++;
    if (decr_log.size() != 0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL single_end decr_count=%0d state=%0d (required 0 0)", decr_log.size(), state_o);
    end
    $display("test_single_press t=%0d pulses=%0d", t, incr_log.size());
  endtask

  task automatic test_down_press();
    int t;
    incr_log.delete(); decr_log.delete();
    btn_dn = 1'b1; t = cyc + 1;
    repeat (8) @(negedge clk);
    btn_dn = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (decr_log.size() != 1 || decr_log[0] != t + 6) begin
      errors++;
      $display("FAIL down_decr count=%0d first=%0d (required 1 pulse at %0d)",
               decr_log.size(), (decr_log.size() > 0) ? decr_log[0] : -1, t + 6);
    end
    checks++;
    if (incr_log.size() != 0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL down_end incr_count=%0d state=%0d (required 0 0)", incr_log.size(), state_o);
    end
    $display("test_down_press t=%0d pulses=%0d", t, decr_log.size());
  endtask

  task automatic test_repeat();
    int t;
    int exp_off[6] = '{6, 16, 19, 22, 25, 28};
    incr_log.delete(); decr_log.delete();
    btn_up = 1'b1; t = cyc + 1;
    repeat (21) @(negedge clk);
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL repeat_state state=%0d (required 3)", state_o);
    end
    repeat (8) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (incr_log.size() != 6) begin
      errors++;
      $display("FAIL repeat_count count=%0d (required 6)", incr_log.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= incr_log.size() || incr_log[i] != t + exp_off[i]) begin
        errors++;
        $display("FAIL repeat_pulse%0d got=%0d (required %0d)",
                 i, (i < incr_log.size()) ? incr_log[i] : -1, t + exp_off[i]);
      end
    end
    checks++;
    if (state_o !== 3'd0 || decr_log.size() != 0) begin
      errors++;
      $display("FAIL repeat_end state=%0d decr_count=%0d (required 0 0)", state_o, decr_log.size());
    end
    $display("test_repeat t=%0d pulses=%0d", t, incr_log.size());
  endtask

  task automatic test_glitch();
    int t;
    incr_log.delete(); decr_log.delete();
    btn_dn = 1'b1; t = cyc + 1;
    repeat (3) @(negedge clk);
    btn_dn = 1'b0;
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL glitch_debounce state=%0d (required 1)", state_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL glitch_idle state=%0d (required 0)", state_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (decr_log.size() != 0 || incr_log.size() != 0) begin
      errors++;
      $display("FAIL glitch_pulses decr=%0d incr=%0d (required 0 0)", decr_log.size(), incr_log.size());
    end
    $display("test_glitch t=%0d", t);
  endtask

  task automatic test_lock_mid();
    int t;
    incr_log.delete(); decr_log.delete();
    btn_up = 1'b1; t = cyc + 1;
    repeat (12) @(negedge clk);
    btn_dn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL lock_entry state=%0d (required 4)", state_o);
    end
    repeat (11) @(negedge clk);
    btn_up = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL lock_one_held state=%0d (required 4)", state_o);
    end
    btn_dn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL lock_release_lag state=%0d (required 4)", state_o);
    end
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL lock_exit state=%0d (required 0)", state_o);
    end
    checks++;
    if (incr_log.size() != 1 || incr_log[0] != t + 6 || decr_log.size() != 0) begin
      errors++;
      $display("FAIL lock_pulses incr=%0d first=%0d decr=%0d (required 1 at %0d, 0)",
               incr_log.size(), (incr_log.size() > 0) ? incr_log[0] : -1, decr_log.size(), t + 6);
    end
    repeat (4) @(negedge clk);
    $display("test_lock_mid t=%0d", t);
  endtask

  task automatic test_both();
    int t;
    incr_log.delete(); decr_log.delete();
    btn_up = 1'b1; btn_dn = 1'b1; t = cyc + 1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 3'd4) begin
      errors++;
      $display("FAIL both_lock state=%0d (required 4)", state_o);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (state_o !== 3'd4 || incr_log.size() != 0 || decr_log.size() != 0) begin
      errors++;
      $display("FAIL both_hold state=%0d incr=%0d decr=%0d (required 4 0 0)",
               state_o, incr_log.size(), decr_log.size());
    end
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL both_exit state=%0d (required 0)", state_o);
    end
    repeat (4) @(negedge clk);
    $display("test_both t=%0d", t);
  endtask

  task automatic test_reset_mid();
    int t;
    incr_log.delete(); decr_log.delete();
    btn_up = 1'b1; t = cyc + 1;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (state_o !== 3'd0 || incr_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort state=%0d incr=%b (required 0 0)", state_o, incr_o);
    end
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (incr_log.size() != 2) begin
      errors++;
      $display("FAIL rstmid_count count=%0d (required 2)", incr_log.size());
    end
    checks++;
    if (incr_log.size() < 1 || incr_log[0] != t + 6) begin
      errors++;
      $display("FAIL rstmid_first got=%0d (required %0d)",
               (incr_log.size() > 0) ? incr_log[0] : -1, t + 6);
    end
    checks++;
    if (incr_log.size() < 2 || incr_log[1] != t + 21) begin
      errors++;
      $display("FAIL rstmid_second got=%0d (required %0d)",
               (incr_log.size() > 1) ? incr_log[1] : -1, t + 21);
    end
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_end state=%0d (required 0)", state_o);
    end
    $display("test_reset_mid t=%0d pulses=%0d", t, incr_log.size());
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    test_reset();
    test_single_press();
    test_down_press();
    test_repeat();
    test_glitch();
    test_lock_mid();
    test_both();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_btn_ctrl.md
UPDOWN_BTN_CTRL -- requirements
Module: updown_btn_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20'd50000, meaning the number of consecutive stable cycles before a press is accepted.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 20'd500000, meaning the delay from the first pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 20'd150000, meaning the period between auto-repeat pulses.
REQ-004 All three parameters SHALL be in the range 2..2^20-1; the internal timer SHALL be 20 bits wide.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port btn_up_i, input, 1 bit: raw asynchronous up button, active-high.
REQ-008 The block SHALL have port btn_down_i, input, 1 bit: raw asynchronous down button, active-high.
REQ-009 The block SHALL have port incr_o, output, 1 bit: single-cycle increment pulse to the digit counter.
REQ-010 The block SHALL have port decr_o, output, 1 bit: single-cycle decrement pulse to the digit counter.
REQ-011 The block SHALL have port state_o, output, 3 bits: current FSM state, encoded IDLE=0, DEBOUNCE=1, HOLD=2, REPEAT=3, LOCK=4.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer; a raw change sampled at edge t SHALL be visible as sync_up/sync_dn at edge t+2.
REQ-013 In IDLE, exactly one synced button high SHALL latch dir (up/down), load the timer, and move to DEBOUNCE; both synced buttons high SHALL move to LOCK; none SHALL stay in IDLE.
REQ-014 In DEBOUNCE, the latched button dropping SHALL return the FSM to IDLE; the other button rising SHALL move it to LOCK; no pulse SHALL be emitted in either case.
REQ-015 When the latched button has been synced high for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL emit one pulse on the dir output and enter HOLD with the timer reloaded.
REQ-016 In HOLD, when the button has been held for HOLD_CYCLES further cycles, the FSM SHALL emit one pulse and enter REPEAT.
REQ-017 In REPEAT, the FSM SHALL emit one pulse every REPEAT_CYCLES cycles while the button is held.
REQ-018 In HOLD or REPEAT, release of the latched button SHALL return the FSM to IDLE on the next edge with no pulse; the other button rising SHALL move it to LOCK.
REQ-019 LOCK SHALL emit no pulses and SHALL return to IDLE only after both synced buttons have been low for one cycle.
REQ-020 incr_o and decr_o SHALL be registered, high for exactly one cycle per pulse, never high simultaneously, and never high in two consecutive cycles.
REQ-021 Pulse count SHALL be independent of the downstream counter value; limits 0/9 are enforced downstream.

Reset
REQ-022 While rst_i is high at a clock edge: state SHALL go to IDLE (state_o=0), incr_o=0, decr_o=0, the timer and dir SHALL clear, and the synchronizer flops SHALL clear to 0.
REQ-023 Reset asserted mid-press SHALL abort the press with no pulse. A button still held after reset release SHALL be treated as a new press and debounced from zero.

Verification (bench parameters DEBOUNCE=4, HOLD=10, REPEAT=3; raw rise sampled at edge t)
REQ-024 Up held 8 cycles then released -> exactly one incr_o pulse at edge t+6, decr_o stays 0, state_o ends at 0.
REQ-025 Up held 30 cycles -> incr_o pulses at t+6, t+16, t+19, t+22, t+25, t+28, then no further pulses after release.
REQ-026 Down glitch high 3 cycles, then low -> no decr_o pulse, and state_o returns from 1 to 0.
REQ-027 Up held, then down raised at t+12 -> one incr_o pulse at t+6 only, state_o=4 until both buttons are low, then 0.
REQ-028 Both buttons rise at the same edge -> state_o=4 and no pulses for the full hold.
REQ-029 Up held, rst_i pulsed at t+14 for 1 cycle, up kept held -> pulses at t+6, then the next pulse at t+14+1+2+4 (debounce restarts after reset).
